// File: rtl/mac_acc_pipe.sv
// rtl/mac_acc_pipe.sv - pipelined signed multiply-accumulate with guard bits and saturation
//
// Purpose:
//    Signed DW x DW multiplier feeding an AW = 2*DW+GW accumulator.
//    The accumulator supports LOAD / ADD / SUB / HOLD.
//    It has a sticky signed-overflow flag and optional output saturation.
//    Every register updates on the falling edge of clk.
//    An operation sampled at edge n completes at edge n+3.
//
// Ports:
//    clk          in   1    clock, registers update on the falling edge
//    reset_n      in   1    asynchronous active-low reset
//    stall        in   1    1 = hold every register, ignore inputs
//    valid_in     in   1    operands/instruction are a real operation
//    instruction  in   3    [1:0] op (00 LOAD, 01 ADD, 10 SUB, 11 HOLD), [2] SAT
//    multiplier   in   DW   signed operand A
//    multiplicand in   DW   signed operand B
//    result       out  PW   accumulator low bits, or saturated value when SAT
//    protect      out  GW   accumulator guard bits
//    valid_out    out  1    one-cycle strobe for a completed operation
//    overflow     out  1    sticky accumulator wrap on ADD/SUB

module mac_acc_pipe #(
   parameter int DW = 16,
   parameter int GW = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              stall,
   input  logic              valid_in,
   input  logic [2:0]        instruction,
   input  logic [DW-1:0]     multiplier,
   input  logic [DW-1:0]     multiplicand,
   output logic [2*DW-1:0]   result,
   output logic [GW-1:0]     protect,
   output logic              valid_out,
   output logic              overflow
);

   localparam int PW = 2 * DW;
   localparam int AW = PW + GW;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   // Stage 1: captured operands and instruction.
   logic              s1_valid_q;
   logic [2:0]        s1_instr_q;
   logic [DW-1:0]     s1_a_q;
   logic [DW-1:0]     s1_b_q;

   // Stage 2: product.
   // The product is registered a second time (s3_*) so the multiplier has a
   // full cycle of slack. That second register also puts the accumulate edge
   // three edges after sampling.
   logic              s2_valid_q;
   logic [2:0]        s2_instr_q;
   logic [PW-1:0]     s2_p_q;

   logic              s3_valid_q;
   logic [2:0]        s3_instr_q;
   logic [PW-1:0]     s3_p_q;

   // Accumulator and registered outputs.
   logic [AW-1:0]     acc_q;
   logic [PW-1:0]     result_q;
   logic [GW-1:0]     protect_q;
   logic              valid_out_q;
   logic              overflow_q;

   // Accumulate-stage next-state signals.
   logic signed [PW-1:0] prod;
   logic [AW-1:0]     p_ext;
   logic [AW-1:0]     acc_d;
   logic [PW-1:0]     result_d;
   logic              ovf_hit;
   logic              in_range;

   assign prod = $signed(s1_a_q) * $signed(s1_b_q);

   always_comb begin
      p_ext    = {{GW{s3_p_q[PW-1]}}, s3_p_q};
      acc_d    = acc_q;
      ovf_hit  = 1'b0;
      case (s3_instr_q[1:0])
         OP_LOAD: acc_d = p_ext;
         OP_ADD: begin
            acc_d   = acc_q + p_ext;
            // Same-sign operands producing a result of the other sign.
            ovf_hit = (acc_q[AW-1] == p_ext[AW-1]) && (acc_d[AW-1] != acc_q[AW-1]);
         end
         OP_SUB: begin
            acc_d   = acc_q - p_ext;
            // Opposite-sign operands whose result flips away from acc's sign.
            ovf_hit = (acc_q[AW-1] != p_ext[AW-1]) && (acc_d[AW-1] != acc_q[AW-1]);
         end
         OP_HOLD: acc_d = acc_q;
         default: acc_d = acc_q;
      endcase

      // The value fits in PW signed bits when bits [AW-1:PW-1] are all equal.
      in_range = (&acc_d[AW-1:PW-1]) || !(|acc_d[AW-1:PW-1]);
      if (!s3_instr_q[2] || in_range) begin
         result_d = acc_d[PW-1:0];
      end else if (acc_d[AW-1]) begin
         result_d = {1'b1, {(PW-1){1'b0}}};
      end else begin
         result_d = {1'b0, {(PW-1){1'b1}}};
      end
   end

   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_instr_q  <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_instr_q  <= '0;
         s2_p_q      <= '0;
         s3_valid_q  <= 1'b0;
         s3_instr_q  <= '0;
         s3_p_q      <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         protect_q   <= '0;
         valid_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (!stall) begin
         s1_valid_q  <= valid_in;
         s1_instr_q  <= instruction;
         s1_a_q      <= multiplier;
         s1_b_q      <= multiplicand;

         s2_valid_q  <= s1_valid_q;
         s2_instr_q  <= s1_instr_q;
         s2_p_q      <= prod;

         s3_valid_q  <= s2_valid_q;
         s3_instr_q  <= s2_instr_q;
         s3_p_q      <= s2_p_q;

         valid_out_q <= s3_valid_q;
         // Bubbles leave acc and the visible result untouched.
         if (s3_valid_q) begin
            acc_q      <= acc_d;
            result_q   <= result_d;
            protect_q  <= acc_d[AW-1:PW];
            overflow_q <= overflow_q | ovf_hit;
         end
      end
   end

   assign result    = result_q;
   assign protect   = protect_q;
   assign valid_out = valid_out_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// tb/tb_mac_acc_pipe.sv - scoreboard testbench for mac_acc_pipe

module tb_mac_acc_pipe;

   localparam logic [2:0] LOAD = 3'b000;
   localparam logic [2:0] ADD  = 3'b001;
   localparam logic [2:0] SUB  = 3'b010;
   localparam logic [2:0] HOLD = 3'b011;
   localparam logic [2:0] SAT  = 3'b100;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        valid_in;
   logic [2:0]  instruction;
   logic [15:0] multiplier;
   logic [15:0] multiplicand;
   logic [31:0] result;
   logic [7:0]  protect;
   logic        valid_out;
   logic        overflow;

   always #5 clk = ~clk;

   mac_acc_pipe #(.DW(16), .GW(8)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .stall        (stall),
      .valid_in     (valid_in),
      .instruction  (instruction),
      .multiplier   (multiplier),
      .multiplicand (multiplicand),
      .result       (result),
      .protect      (protect),
      .valid_out    (valid_out),
      .overflow     (overflow)
   );

   typedef struct {
      logic [31:0] res;
      logic [7:0]  prot;
      logic        ovf;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cmp_cnt = 0;
   int   err_cnt = 0;
   int   u_cnt   = 0;   // count of un-stalled, out-of-reset falling edges

   // Monitor: on every live edge, a valid_out must match the queue head.
   logic mon_st, mon_rs;
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         mon_st = stall;
         mon_rs = reset_n;
         #1;
         if (mon_rs && reset_n && !mon_st) begin
            u_cnt++;
            if (valid_out) begin
               cmp_cnt++;
               if (sb.size() == 0) begin
                  err_cnt++;
                  $display("FAIL spurious_valid_out: edge %0d result=%h protect=%h, required no output", u_cnt, result, protect);
               end else begin
                  mon_e = sb.pop_front();
                  if (result !== mon_e.res || protect !== mon_e.prot || overflow !== mon_e.ovf || u_cnt != mon_e.due) begin
                     err_cnt++;
                     $display("FAIL op_result: got res=%h prot=%h ovf=%b edge=%0d, required res=%h prot=%h ovf=%b edge=%0d",
                              result, protect, overflow, u_cnt, mon_e.res, mon_e.prot, mon_e.ovf, mon_e.due);
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      cmp_cnt++;
      if (got !== want) begin
         err_cnt++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] ins, input logic [15:0] a, input logic [15:0] b, input logic st);
      @(posedge clk);
      valid_in     = v;
      instruction  = ins;
      multiplier   = a;
      multiplicand = b;
      stall        = st;
   endtask

   task automatic op(input logic [2:0] ins, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] r, input logic [7:0] p, input logic o);
      exp_t e;
      drive(1'b1, ins, a, b, 1'b0);
      e.res  = r;
      e.prot = p;
      e.ovf  = o;
      e.due  = u_cnt + 4;
      sb.push_back(e);
   endtask

   task automatic bubble();
      drive(1'b0, ADD, 16'h5555, 16'h3333, 1'b0);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_result"},    {32'h0, result},    64'h0);
      chk({tag, "_protect"},   {56'h0, protect},   64'h0);
      chk({tag, "_valid_out"}, {63'h0, valid_out}, 64'h0);
      chk({tag, "_overflow"},  {63'h0, overflow},  64'h0);
   endtask

   initial begin
      reset_n      = 1'b0;
      stall        = 1'b0;
      valid_in     = 1'b0;
      instruction  = LOAD;
      multiplier   = '0;
      multiplicand = '0;
      #3;
      check_zero_outputs("reset_state");
      @(posedge clk);
      @(posedge clk);
      reset_n = 1'b1;

      // Reset mid-stream: in-flight ops are discarded, outputs clear at once.
      drive(1'b1, LOAD, 16'h0007, 16'h0009, 1'b0);
      drive(1'b1, ADD,  16'h0011, 16'h0002, 1'b0);
      @(posedge clk);
      valid_in = 1'b0;
      #2 reset_n = 1'b0;
      #1 check_zero_outputs("async_reset");
      @(posedge clk);
      @(posedge clk);
      reset_n = 1'b1;

      // LOAD 3 * -4
      op(LOAD, 16'h0003, 16'hFFFC, 32'hFFFF_FFF4, 8'hFF, 1'b0);
      bubble();

      // LOAD, ADD, ADD of max positive squares, then again with SAT on the last
      op(LOAD, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 8'h00, 1'b0);
      op(ADD,  16'h7FFF, 16'h7FFF, 32'h7FFE_0002, 8'h00, 1'b0);
      op(ADD,  16'h7FFF, 16'h7FFF, 32'hBFFD_0003, 8'h00, 1'b0);
      op(LOAD, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 8'h00, 1'b0);
      op(ADD,  16'h7FFF, 16'h7FFF, 32'h7FFE_0002, 8'h00, 1'b0);
      op(ADD | SAT, 16'h7FFF, 16'h7FFF, 32'h7FFF_FFFF, 8'h00, 1'b0);

      // SUB sequence, then the same with a 2-cycle stall while ops are in flight
      op(LOAD, 16'h0002, 16'h0005, 32'h0000_000A, 8'h00, 1'b0);
      op(SUB,  16'h0007, 16'h0003, 32'hFFFF_FFF5, 8'hFF, 1'b0);
      op(LOAD, 16'h0002, 16'h0005, 32'h0000_000A, 8'h00, 1'b0);
      op(SUB,  16'h0007, 16'h0003, 32'hFFFF_FFF5, 8'hFF, 1'b0);
      drive(1'b1, LOAD, 16'h1234, 16'h1234, 1'b1);   // ignored under stall
      drive(1'b1, LOAD, 16'h4321, 16'h4321, 1'b1);
      bubble();

      // Bubbles and HOLD ops leave acc = -11
      bubble();
      op(HOLD, 16'h1111, 16'h2222, 32'hFFFF_FFF5, 8'hFF, 1'b0);
      bubble();
      bubble();
      op(HOLD | SAT, 16'h7FFF, 16'h7FFF, 32'hFFFF_FFF5, 8'hFF, 1'b0);
      op(ADD, 16'h0001, 16'h0001, 32'hFFFF_FFF6, 8'hFF, 1'b0);
      bubble();

      // 512 x ADD of 2^30: overflow exactly on the 512th
      op(LOAD, 16'h0000, 16'h0000, 32'h0000_0000, 8'h00, 1'b0);
      for (int i = 1; i <= 512; i++) begin
         logic [39:0] acc_exp;
         acc_exp = 40'(i) << 30;
         op(ADD, 16'h8000, 16'h8000, acc_exp[31:0], acc_exp[39:32], (i == 512));
      end

      // overflow is sticky through LOADs; negative saturation
      op(LOAD, 16'h0001, 16'h0001, 32'h0000_0001, 8'h00, 1'b1);
      op(LOAD, 16'h8000, 16'h7FFF, 32'hC000_8000, 8'hFF, 1'b1);
      op(SUB,  16'h7FFF, 16'h7FFF, 32'h8001_7FFF, 8'hFF, 1'b1);
      op(SUB | SAT, 16'h7FFF, 16'h7FFF, 32'h8000_0000, 8'hFF, 1'b1);
      bubble();

      // Drain the scoreboard within a bounded number of edges
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      #2;
      chk("drain_remaining", 64'(sb.size()), 64'h0);

      // A second reset clears the sticky overflow
      chk("overflow_before_reset", {63'h0, overflow}, 64'h1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check_zero_outputs("final_reset");
      @(posedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
